// File: rtl/aes_pkg.sv
// Shared definitions for the AES ShiftRows datapath: mode encoding, FSM states
// and the mapping from (row, column) to a cell slot in a packed state vector.
package aes_pkg;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Cell slot counted from the LSB end; cell (0,0) occupies the MSBs.
  function automatic int idx(input int r, input int c, input int dim);
    return dim * dim - 1 - (dim * c + r);
  endfunction

endpackage

// File: rtl/shift_rows_seq_row_rotate.sv
// Combinational rotation of one DIM-cell row by a run-time amount.
// Forward rotates left (towards column 0), inverse rotates right.
module row_rotate
  import aes_pkg::*;
#(
  parameter int DIM = 4,
  parameter int W   = 8
) (
  input  logic [DIM*W-1:0]         row_i,
  input  logic [$clog2(DIM)-1:0]   amt_i,
  input  logic                     dir_i,
  output logic [DIM*W-1:0]         row_o
);

  int src;

  // amt_i < DIM, so one conditional subtract replaces a modulo.
  always_comb begin
    row_o = '0;
    src   = 0;
    for (int c = 0; c < DIM; c++) begin
      if (dir_i == MODE_FWD) begin
        src = c + int'(amt_i);
      end else begin
        src = c + DIM - int'(amt_i);
      end
      if (src >= DIM) begin
        src = src - DIM;
      end
      row_o[W*(DIM-1-c) +: W] = row_i[W*(DIM-1-src) +: W];
    end
  end

endmodule

// File: rtl/shift_rows_seq.sv
// Sequential ShiftRows / InvShiftRows: captures a state, rotates one row per
// clock, then holds the result until the downstream stage takes it.
module shift_rows_seq
  import aes_pkg::*;
#(
  parameter int DIM = 4,
  parameter int W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DIM*DIM*W-1:0]   in_state,
  input  logic                   in_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DIM*DIM*W-1:0]   out_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int CW = $clog2(DIM);

  state_t                 state_q;
  logic [CW-1:0]          row_cnt_q;
  logic                   mode_q;
  logic [DIM*DIM*W-1:0]   work_q;
  logic [DIM*DIM*W-1:0]   work_d;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;
  logic [DIM*W-1:0]       row_sel;
  logic [DIM*W-1:0]       row_rot;

  // Gather row row_cnt out of the column-major working register.
  always_comb begin
    row_sel = '0;
    for (int c = 0; c < DIM; c++) begin
      row_sel[W*(DIM-1-c) +: W] = work_q[W*idx(int'(row_cnt_q), c, DIM) +: W];
    end
  end

  row_rotate #(
    .DIM (DIM),
    .W   (W)
  ) u_row_rotate (
    .row_i (row_sel),
    .amt_i (row_cnt_q),
    .dir_i (mode_q),
    .row_o (row_rot)
  );

  always_comb begin
    work_d = work_q;
    for (int c = 0; c < DIM; c++) begin
      work_d[W*idx(int'(row_cnt_q), c, DIM) +: W] = row_rot[W*(DIM-1-c) +: W];
    end
  end

  // in_ready comes from its own flop so it stays low through reset and
  // never depends combinationally on out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      mode_q      <= MODE_FWD;
      work_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            work_q     <= in_state;
            mode_q     <= in_mode;
            row_cnt_q  <= CW'(1);
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          if (row_cnt_q == CW'(DIM - 1)) begin
            row_cnt_q   <= '0;
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            row_cnt_q <= row_cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = work_q;

endmodule

// File: tb/tb_shift_rows_seq.sv
// Bench for shift_rows_seq: a 4x4x8 instance and a 2x2x1 instance checked
// against an array-based ShiftRows reference model.
module tb_shift_rows_seq;

  localparam int D4 = 4;
  localparam int W4 = 8;
  localparam int N4 = D4 * D4 * W4;
  localparam int D2 = 2;
  localparam int W2 = 1;
  localparam int N2 = D2 * D2 * W2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [N4-1:0] in_state4, out_state4;
  logic          in_mode4, in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [N2-1:0] in_state2, out_state2;
  logic          in_mode2, in_valid2, in_ready2, out_valid2, out_ready2, busy2;

  int n_tests = 0;
  int n_fail  = 0;

  shift_rows_seq #(.DIM(D4), .W(W4)) dut4 (
    .clk(clk), .reset(reset),
    .in_state(in_state4), .in_mode(in_mode4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_state(out_state4), .out_valid(out_valid4), .out_ready(out_ready4), .busy(busy4)
  );

  shift_rows_seq #(.DIM(D2), .W(W2)) dut2 (
    .clk(clk), .reset(reset),
    .in_state(in_state2), .in_mode(in_mode2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_state(out_state2), .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2)
  );

  // Reference: out(r,c) = in(r,(c+r) mod d) forward, in(r,(c-r) mod d) inverse.
  function automatic logic [127:0] ref_shift(input logic [127:0] s, input logic inv,
                                             input int d, input int w);
    logic [127:0] o;
    int src;
    o = '0;
    for (int r = 0; r < d; r++) begin
      for (int c = 0; c < d; c++) begin
        src = inv ? ((c - r + d) % d) : ((c + r) % d);
        for (int b = 0; b < w; b++) begin
          o[w*(d*d-1-(d*c+r)) + b] = s[w*(d*d-1-(d*src+r)) + b];
        end
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one block into dut4 and waits for its result; no checking here.
  task automatic run4(input logic [127:0] st, input logic md, output int lat,
                      output logic [127:0] res, output bit ok);
    int g;
    ok = 1'b1;
    g  = 0;
    while (!in_ready4 && g < 30) begin tick(); g++; end
    if (!in_ready4) ok = 1'b0;
    in_state4 = st; in_mode4 = md; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!out_valid4 && lat < 40);
    if (!out_valid4) ok = 1'b0;
    res = out_state4;
    if (out_ready4) tick();
  endtask

  task automatic run2(input logic [3:0] st, input logic md, output int lat,
                      output logic [3:0] res, output bit ok);
    int g;
    ok = 1'b1;
    g  = 0;
    while (!in_ready2 && g < 30) begin tick(); g++; end
    if (!in_ready2) ok = 1'b0;
    in_state2 = st; in_mode2 = md; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!out_valid2 && lat < 40);
    if (!out_valid2) ok = 1'b0;
    res = out_state2;
    if (out_ready2) tick();
  endtask

  localparam logic [127:0] VEC     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VEC_FWD = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] VEC_INV = 128'h000d0a0704010e0b0805020f0c090603;

  task automatic test_reset();
    reset = 1'b1;
    in_state4 = '0; in_mode4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b1;
    in_state2 = '0; in_mode2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
    tick(); tick();
    n_tests++; if (in_ready4 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready4); end
    n_tests++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid4); end
    n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy4); end
    n_tests++; if (out_state4 !== '0) begin n_fail++; $display("FAIL reset_out_state got=%h exp=0", out_state4); end
    n_tests++; if (out_state2 !== '0) begin n_fail++; $display("FAIL reset_out_state2 got=%b exp=0", out_state2); end
    reset = 1'b0;
    tick();
    n_tests++; if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", in_ready4); end
    n_tests++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL release_in_ready2 got=%b exp=1", in_ready2); end
  endtask

  task automatic test_fwd_vector();
    int lat; logic [127:0] res; bit ok;
    run4(VEC, 1'b0, lat, res, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL fwd_timeout got=timeout exp=handshake"); end
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL fwd_latency got=%0d exp=3", lat); end
    n_tests++; if (res !== VEC_FWD) begin n_fail++; $display("FAIL fwd_data got=%h exp=%h", res, VEC_FWD); end
  endtask

  task automatic test_inv_vector();
    int lat; logic [127:0] res, r1, r2; bit ok;
    run4(VEC, 1'b1, lat, res, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL inv_timeout got=timeout exp=handshake"); end
    n_tests++; if (res !== VEC_INV) begin n_fail++; $display("FAIL inv_data got=%h exp=%h", res, VEC_INV); end
    r1 = rand128();
    run4(r1, 1'b0, lat, r2, ok);
    run4(r2, 1'b1, lat, res, ok);
    n_tests++; if (res !== r1) begin n_fail++; $display("FAIL roundtrip got=%h exp=%h", res, r1); end
  endtask

  task automatic test_dim2();
    int lat; logic [3:0] res, e; bit ok;
    run2(4'b0100, 1'b0, lat, res, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL dim2_timeout got=timeout exp=handshake"); end
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL dim2_latency got=%0d exp=1", lat); end
    n_tests++; if (res !== 4'b0001) begin n_fail++; $display("FAIL dim2_0100 got=%b exp=0001", res); end
    run2(4'b1010, 1'b0, lat, res, ok);
    n_tests++; if (res !== 4'b1010) begin n_fail++; $display("FAIL dim2_1010 got=%b exp=1010", res); end
    for (int v = 0; v < 16; v++) begin
      for (int m = 0; m < 2; m++) begin
        e = ref_shift(128'(v), m[0], D2, W2);
        run2(4'(v), m[0], lat, res, ok);
        n_tests++; if (res !== e) begin n_fail++; $display("FAIL dim2_sweep in=%b mode=%0d got=%b exp=%b", 4'(v), m, res, e); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a, b, held, res; logic mb; int g;
    a = rand128(); b = rand128(); mb = 1'b1;
    out_ready4 = 1'b0;
    in_state4 = a; in_mode4 = 1'b0; in_valid4 = 1'b1;
    tick();
    in_state4 = b; in_mode4 = mb;   // pending offer held through DONE
    g = 0;
    while (!out_valid4 && g < 20) begin tick(); g++; end
    n_tests++; if (out_valid4 !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got=%b exp=1", out_valid4); end
    held = out_state4;
    n_tests++; if (held !== ref_shift(a, 1'b0, D4, W4)) begin n_fail++; $display("FAIL bp_data got=%h exp=%h", held, ref_shift(a, 1'b0, D4, W4)); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++; if (out_state4 !== held) begin n_fail++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", i, out_state4, held); end
      n_tests++; if (in_ready4 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready4); end
      n_tests++; if (out_valid4 !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid4); end
    end
    out_ready4 = 1'b1;
    tick();
    n_tests++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b exp=0", out_valid4); end
    n_tests++; if (in_ready4 !== 1'b1 || busy4 !== 1'b0) begin n_fail++; $display("FAIL bp_no_same_cycle got=rdy%b/busy%b exp=rdy1/busy0", in_ready4, busy4); end
    tick();
    in_valid4 = 1'b0;
    n_tests++; if (busy4 !== 1'b1 || in_ready4 !== 1'b0) begin n_fail++; $display("FAIL bp_accept got=busy%b/rdy%b exp=busy1/rdy0", busy4, in_ready4); end
    g = 0;
    while (!out_valid4 && g < 20) begin tick(); g++; end
    res = out_state4;
    n_tests++; if (res !== ref_shift(b, mb, D4, W4)) begin n_fail++; $display("FAIL bp_second got=%h exp=%h", res, ref_shift(b, mb, D4, W4)); end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    int lat; logic [127:0] res, s; bit ok; logic m;
    in_state4 = rand128(); in_mode4 = 1'b0; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    n_tests++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid4); end
    n_tests++; if (out_state4 !== '0) begin n_fail++; $display("FAIL rst_mid_state got=%h exp=0", out_state4); end
    n_tests++; if (busy4 !== 1'b0 || in_ready4 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl got=busy%b/rdy%b exp=busy0/rdy0", busy4, in_ready4); end
    tick();
    reset = 1'b0;
    tick();
    n_tests++; if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_release got=%b exp=1", in_ready4); end
    s = rand128(); m = 1'($urandom_range(0, 1));
    run4(s, m, lat, res, ok);
    n_tests++; if (!ok || res !== ref_shift(s, m, D4, W4)) begin n_fail++; $display("FAIL rst_mid_next got=%h exp=%h", res, ref_shift(s, m, D4, W4)); end
  endtask

  task automatic test_input_toggle();
    logic [127:0] s, e; logic m; int g;
    s = rand128(); m = 1'b1; e = ref_shift(s, m, D4, W4);
    in_state4 = s; in_mode4 = m; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    g = 0;
    while (!out_valid4 && g < 20) begin
      in_state4 = ~in_state4; in_mode4 = ~in_mode4;
      tick(); g++;
    end
    n_tests++; if (out_valid4 !== 1'b1 || out_state4 !== e) begin n_fail++; $display("FAIL toggle got=%h exp=%h", out_state4, e); end
    tick();
  endtask

  task automatic test_random();
    int lat; logic [127:0] s, res; bit ok; logic m;
    for (int i = 0; i < 20; i++) begin
      s = rand128(); m = 1'($urandom_range(0, 1));
      run4(s, m, lat, res, ok);
      n_tests++; if (!ok || lat !== 3 || res !== ref_shift(s, m, D4, W4)) begin
        n_fail++; $display("FAIL random i=%0d lat=%0d got=%h exp=%h", i, lat, res, ref_shift(s, m, D4, W4));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_q[$];
    logic [127:0] e;
    int last, accepts, g;
    last = -1; accepts = 0;
    out_ready4 = 1'b1;
    in_state4 = rand128(); in_mode4 = 1'($urandom_range(0, 1)); in_valid4 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (in_ready4) begin
        exp_q.push_back(ref_shift(in_state4, in_mode4, D4, W4));
        if (last >= 0) begin
          n_tests++; if (i - last !== D4 + 1) begin n_fail++; $display("FAIL b2b_period got=%0d exp=%0d", i - last, D4 + 1); end
        end
        last = i; accepts++;
      end
      tick();
      if (out_valid4) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_tests++; if (out_state4 !== e) begin n_fail++; $display("FAIL b2b_data got=%h exp=%h", out_state4, e); end
      end
      in_state4 = rand128(); in_mode4 = 1'($urandom_range(0, 1));
    end
    in_valid4 = 1'b0;
    g = 0;
    while (exp_q.size() > 0 && g < 20) begin
      tick(); g++;
      if (out_valid4) begin
        e = exp_q.pop_front();
        n_tests++; if (out_state4 !== e) begin n_fail++; $display("FAIL b2b_drain got=%h exp=%h", out_state4, e); end
      end
    end
    n_tests++; if (accepts < 11 || exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_count got=%0d/%0d exp>=11/0", accepts, exp_q.size()); end
    tick();
  endtask

  initial begin
    test_reset();
    test_fwd_vector();
    test_inv_vector();
    test_dim2();
    test_backpressure();
    test_reset_mid_shift();
    test_input_toggle();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_rows_seq.md
# shift_rows_seq

Parametrised, sequential AES ShiftRows / InvShiftRows engine for a DIM×DIM state of W-bit cells. It sits in the round datapath between SubBytes and MixColumns. It accepts a whole state over a valid/ready handshake and rotates one row per clock. It presents the result until the downstream stage accepts it. It generalises the fixed 2×2, forward-only ShiftRows with a mode select, back-pressure, reset and arbitrary dimension.

## Interface
- DIM, 4: state rows = columns; legal range 2..8.
- W, 8: bits per cell (8 for AES, 1 allowed for small benches).
- clk  in  1: rising-edge clock.
- reset  in  1: asynchronous, active-high.
- in_state  in  DIM*DIM*W: input state; cell (r,c), zero-based, at bits [W*(DIM*DIM-1-(DIM*c+r)) +: W], so cell (0,0) is the MSBs.
- in_mode  in  1: 0 = forward ShiftRows, 1 = inverse; sampled only at acceptance.
- in_valid  in  1: input offer.
- in_ready  out  1: block can accept.
- out_state  out  DIM*DIM*W: result, same packing as in_state.
- out_valid  out  1: result available.
- out_ready  in  1: downstream accepts.
- busy  out  1: high in SHIFT.

## Operation
- Forward: out(r,c) = in(r,(c+r) mod DIM). Inverse: out(r,c) = in(r,(c−r) mod DIM).
- Row 0 is never rotated.
- States:
  - IDLE: in_ready=1. in_valid&in_ready → capture in_state into the working register, latch in_mode, row_cnt←1, go to SHIFT.
  - SHIFT: rotate row row_cnt of the working register by row_cnt cells (left for forward, right for inverse); row_cnt+1. At row_cnt=DIM−1, rotate and go to DONE.
  - DONE: out_valid=1, out_state = working register. out_ready → IDLE. Without out_ready, hold with out_state stable.
- in_ready is 0 in SHIFT and DONE. An offered input waits; it is neither dropped nor partially captured.
- No same-cycle handoff from DONE to accept; a new block is taken at the earliest in the following IDLE cycle.
- Mode and data changes on the inputs after acceptance have no effect on the block in flight.
- Rotation amount row_cnt is in 0..DIM−1, so the mod-DIM index never exceeds one wrap. row_cnt width is clog2(DIM).
- Reset, asserted at any time including mid-SHIFT or in DONE, discards the block in flight:
  - state←IDLE, row_cnt←0, working register←0.
  - out_state=0, out_valid=0, busy=0.
  - in_ready=0 while reset is high, then 1 in the first cycle after release.

## Timing
- Acceptance at edge N. SHIFT edges N+1..N+DIM−1. out_valid rises after edge N+DIM−1, i.e. latency DIM−1 edges (3 for DIM=4, 1 for DIM=2).
- Minimum period per block: DIM+1 cycles, with out_ready held high.
- out_valid falls on the edge where out_valid&out_ready; in_ready rises on that same edge.
- All outputs are registered or decoded from state only. There are no combinational paths from in_* to out_* or from out_ready to in_ready.

## Structure
- Shared package aes_pkg: mode constants (MODE_FWD=0, MODE_INV=1), cell-index function idx(r,c,DIM), and the FSM state typedef {IDLE, SHIFT, DONE}.
- One sub-module, row_rotate: combinational rotation of a DIM-cell, W-bit row by a run-time amount and direction. It is instantiated once and muxed onto row row_cnt.

## Test plan
- DIM=4, W=8, forward, cells k=DIM*c+r hold value k (00..0F): out columns = 00 05 0A 0F | 04 09 0E 03 | 08 0D 02 07 | 0C 01 06 0B. out_valid appears 3 edges after acceptance.
- Same input, inverse: out = 00 0D 0A 07 | 04 01 0E 0B | 08 05 02 0F | 0C 09 06 03. Forward followed by inverse returns the original state.
- DIM=2, W=1: in_state=4'b0100 gives out_state=4'b0001; 4'b1010 is unchanged. Latency is 1 edge.
- Back-pressure: out_ready low 5 cycles in DONE. out_state is stable and in_ready=0, and a pending in_valid is accepted only in the IDLE cycle after the out_valid&out_ready edge.
- Reset asserted during the second SHIFT cycle: out_valid=0, out_state=0 immediately. in_ready=1 the cycle after release, and the next block completes with correct data.
- in_mode and in_state toggled every cycle after acceptance: result matches the values captured at acceptance.
